// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS instruction fields into 32-bit words, buffers
// them in a small FIFO and streams them out with an auto-incrementing byte
// address for the instruction-memory loader.
// Optional feature: define INSTR_ENC_ZERO_CHK_EN to drop (and flag) field
// sets that would write register $0.
module instr_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_kind,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [15:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_zero
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    K_ADD = 3'd0,
    K_SUB = 3'd1,
    K_AND = 3'd2,
    K_OR  = 3'd3,
    K_SLT = 3'd4,
    K_LW  = 3'd5,
    K_SW  = 3'd6,
    K_BEQ = 3'd7
  } kind_e;

  logic [31:0] mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        accept;
  logic        do_push;
  logic        do_pop;
  logic [31:0] enc_word;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full      = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;
  assign out_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign accept    = in_valid && !full;
  assign do_pop    = !empty && out_ready;

  // Field set to 32-bit word; R-type shares op 0 and selects by func.
  always_comb begin
    enc_word = '0;
    case (kind_e'(in_kind))
      K_ADD: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      K_SUB: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      K_AND: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      K_OR:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      K_SLT: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      K_LW:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      K_BEQ: enc_word = {6'b000100, in_rs, in_rt, in_imm};
    endcase
  end

`ifdef INSTR_ENC_ZERO_CHK_EN
  logic writes_zero;

  // R-type with rd = 0 and lw with rt = 0 target $0.
  always_comb begin
    writes_zero = 1'b0;
    if (in_kind <= 3'd4)
      writes_zero = (in_rd == 5'd0);
    else if (kind_e'(in_kind) == K_LW)
      writes_zero = (in_rt == 5'd0);
  end

  // Handshake still completes for a dropped set; only the push is suppressed.
  assign do_push = accept && !writes_zero;

  // Sticky drop flag, cleared only by reset or clr.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      err_zero <= 1'b0;
    else if (accept && writes_zero)
      err_zero <= 1'b1;
  end
`else
  assign do_push  = accept;
  assign err_zero = 1'b0;
`endif

  // Storage write; suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && do_push)
      mem[wr_ptr[PW-1:0]] <= enc_word;
  end

  // Pointer and address bookkeeping; clr outranks push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_addr <= BASE_ADDR;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_addr <= out_addr + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle
// on two instances (BASE_ADDR 0 and an address that wraps), plus directed
// vectors with literal expectations.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] WBASE = 32'hFFFF_FFF8;
`ifdef INSTR_ENC_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif
  localparam int FUNCT [5] = '{32, 34, 36, 37, 42};
  localparam int OPC   [3] = '{35, 43, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;

  logic        a_in_ready, a_out_valid, a_err;
  logic [31:0] a_out_data, a_out_addr;
  logic [2:0]  a_level;
  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_out_data, b_out_addr;
  logic [2:0]  b_level;

  int n_chk = 0;
  int n_pass = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_addr(a_out_addr), .level(a_level), .err_zero(a_err)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(WBASE)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_addr(b_out_addr), .level(b_level), .err_zero(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference encoding from field weights, not bit concatenation.
  function automatic logic [31:0] enc(input int k, input int rs, input int rt,
                                      input int rd, input int imm);
    longint w;
    if (k < 5) w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11) + FUNCT[k];
    else       w = longint'(OPC[k-5]) * (longint'(1) << 26) + longint'(rs) * (2**21)
                   + longint'(rt) * (2**16) + imm;
    return w[31:0];
  endfunction

  // Model state
  logic [31:0] mq [$];
  logic [31:0] m_addr_a, m_addr_b;
  bit          m_err;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    bit acc, pop, wz;
    if (!rst_n || clr) begin
      mq.delete();
      m_addr_a = 32'h0;
      m_addr_b = WBASE;
      m_err    = 1'b0;
      m_live   = 1'b1;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && out_ready;
      wz  = (in_kind < 3'd5 && in_rd == 5'd0) || (in_kind == 3'd5 && in_rt == 5'd0);
      if (pop) begin
        void'(mq.pop_front());
        m_addr_a = m_addr_a + 32'd4;
        m_addr_b = m_addr_b + 32'd4;
      end
      if (acc) begin
        if (ZCHK && wz) m_err = 1'b1;
        else mq.push_back(enc(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm)));
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("a_in_ready",  {31'b0, a_in_ready},  {31'b0, mq.size() < DEPTH});
      chk("a_out_valid", {31'b0, a_out_valid}, {31'b0, mq.size() > 0});
      chk("a_level",     {29'b0, a_level},     32'(mq.size()));
      chk("a_out_data",  a_out_data,           (mq.size() > 0) ? mq[0] : 32'h0);
      chk("a_out_addr",  a_out_addr,           m_addr_a);
      chk("a_err_zero",  {31'b0, a_err},       {31'b0, m_err});
      chk("b_level",     {29'b0, b_level},     32'(mq.size()));
      chk("b_out_data",  b_out_data,           (mq.size() > 0) ? mq[0] : 32'h0);
      chk("b_out_addr",  b_out_addr,           m_addr_b);
      chk("b_in_ready",  {31'b0, b_in_ready},  {31'b0, mq.size() < DEPTH});
      chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, mq.size() > 0});
      chk("b_err_zero",  {31'b0, b_err},       {31'b0, m_err});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input int rs, input int rt, input int rd, input int imm);
    in_valid = 1'b1;
    in_kind  = 3'(k);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 16'(imm);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic flush();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] b_seq [4];
    b_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Reset state
    repeat (2) tick();
    chk("rst_level",     {29'b0, a_level}, 32'd0);
    chk("rst_in_ready",  {31'b0, a_in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_out_data",  a_out_data, 32'h0);
    chk("rst_out_addr",  a_out_addr, 32'h0);
    chk("rst_b_addr",    b_out_addr, WBASE);
    chk("rst_err",       {31'b0, a_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // add with out_ready low: visible one cycle later
    push(0, 1, 2, 3, 0);
    tick();
    idle();
    chk("add_valid", {31'b0, a_out_valid}, 32'd1);
    chk("add_data",  a_out_data, 32'h0022_1820);
    chk("add_addr",  a_out_addr, 32'h0);
    chk("add_level", {29'b0, a_level}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_addr", a_out_addr, 32'd4);

    // lw then beq streaming back-to-back
    flush();
    out_ready = 1'b1;
    push(5, 29, 8, 0, 16'hFFFC);
    tick();
    chk("lw_data", a_out_data, 32'h8FA8_FFFC);
    chk("lw_addr", a_out_addr, 32'h0);
    push(7, 1, 2, 0, 16'h0003);
    tick();
    idle();
    chk("beq_data", a_out_data, 32'h1022_0003);
    chk("beq_addr", a_out_addr, 32'h4);
    tick();
    chk("drain_valid", {31'b0, a_out_valid}, 32'd0);
    out_ready = 1'b0;

    // Fill to full, refuse extra pushes, then drain in order
    flush();
    push(1, 3, 4, 5, 0);   tick();
    push(2, 6, 7, 8, 0);   tick();
    push(3, 9, 10, 11, 0); tick();
    push(4, 12, 13, 14, 0); tick();
    chk("full_ready", {31'b0, a_in_ready}, 32'd0);
    chk("full_level", {29'b0, a_level}, 32'd4);
    chk("full_head",  a_out_data, 32'h0064_2822);
    push(6, 1, 2, 0, 16'h0010);
    tick();
    chk("refused_level", {29'b0, a_level}, 32'd4);
    chk("b_addr_0", b_out_addr, b_seq[0]);
    out_ready = 1'b1;       // pop while full: push still refused this cycle
    tick();
    idle();
    chk("popfull_level", {29'b0, a_level}, 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("a_addr_seq", a_out_addr, 32'(4 * i));
      chk("b_addr_seq", b_out_addr, b_seq[i]);
      tick();
    end
    out_ready = 1'b0;

    // clr together with push and pop
    flush();
    push(0, 1, 1, 1, 0); tick();
    push(0, 2, 2, 2, 0); tick();
    clr = 1'b1;
    out_ready = 1'b1;
    push(1, 3, 3, 3, 0);
    tick();
    clr = 1'b0;
    idle();
    out_ready = 1'b0;
    chk("clr_level", {29'b0, a_level}, 32'd0);
    chk("clr_valid", {31'b0, a_out_valid}, 32'd0);
    chk("clr_addr",  a_out_addr, 32'h0);
    chk("clr_b_addr", b_out_addr, WBASE);
    tick();
    chk("clr_quiet", {31'b0, a_out_valid}, 32'd0);

    // Writes to $0
    chk("z_ready", {31'b0, a_in_ready}, 32'd1);
    push(3, 1, 2, 0, 0);
    tick();
    idle();
`ifdef INSTR_ENC_ZERO_CHK_EN
    chk("z_level", {29'b0, a_level}, 32'd0);
    chk("z_err",   {31'b0, a_err}, 32'd1);
    push(5, 3, 0, 0, 16'h0004);
    tick();
    idle();
    chk("zlw_level", {29'b0, a_level}, 32'd0);
    chk("zlw_err",   {31'b0, a_err}, 32'd1);
`else
    chk("z_data", a_out_data, 32'h0022_0025);
    chk("z_err",  {31'b0, a_err}, 32'd0);
`endif
    flush();
    chk("z_clr_err", {31'b0, a_err}, 32'd0);

    // Mixed traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      in_kind   = 3'($urandom_range(0, 7));
      in_rs     = 5'($urandom);
      in_rt     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      in_rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      in_imm    = 16'($urandom);
      tick();
    end
    clr = 1'b0;
    out_ready = 1'b0;

    // Reset mid-stream
    push(2, 4, 5, 6, 0); tick();
    push(2, 7, 8, 9, 0); tick();
    rst_n = 1'b0;
    tick();
    idle();
    chk("mid_rst_level", {29'b0, a_level}, 32'd0);
    chk("mid_rst_addr",  a_out_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
